comb_logic_core: RTL and testbench

- Four-input, two-output logic block.
- Evaluates two fixed Boolean functions of single-bit inputs A, B, C, D.
- Presents results Y1 and Y2 as registered outputs, giving downstream logic glitch-free signals.
- Functions are set by truth-table parameters, so the same block serves other 4-input decode needs in the design.

---
 rtl/comb_logic_core_pkg.sv | 14 +
 rtl/comb_logic_sync.sv | 38 +++
 rtl/comb_logic_core.sv | 49 ++++
 tb/tb_comb_logic_core.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/comb_logic_core_pkg.sv
// Shared constants for comb_logic_core: default truth tables and synchronizer depth limit.
// Truth tables are indexed by {A,B,C,D} with A as the most significant bit.
package comb_logic_core_pkg;

  typedef logic [3:0] comb_idx_t;

  // Y1 = (A & ~B) | (C & D)
  localparam logic [15:0] COMB_Y1_TT_DEFAULT = 16'h8F88;
  // Y2 = A ^ B ^ C ^ D
  localparam logic [15:0] COMB_Y2_TT_DEFAULT = 16'h6996;

  localparam int COMB_SYNC_STAGES_MAX = 3;

endpackage

// File: rtl/comb_logic_sync.sv
// Per-bit N-stage input synchronizer with async active-low clear; STAGES = 0 is a wire.
// Latency: STAGES edges. Backpressure: none, samples every edge.
module comb_logic_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
    end else begin : g_stages
      logic [WIDTH-1:0] stage [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/comb_logic_core.sv
// Registered 4-input truth-table decoder producing Y1/Y2 from {A,B,C,D}.
// Latency: SYNC_STAGES + 1 edges. Backpressure: none, outputs reload every edge.
module comb_logic_core
  import comb_logic_core_pkg::*;
#(
  parameter logic [15:0] Y1_TT       = COMB_Y1_TT_DEFAULT,
  parameter logic [15:0] Y2_TT       = COMB_Y2_TT_DEFAULT,
  parameter int          SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic Y1,
  output logic Y2
);

  generate
    if (SYNC_STAGES < 0 || SYNC_STAGES > COMB_SYNC_STAGES_MAX) begin : g_bad_cfg
      $error("comb_logic_core: SYNC_STAGES must be within 0..3");
    end
  endgenerate

  comb_idx_t idx;

  comb_logic_sync #(
    .WIDTH  (4),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({A, B, C, D}),
    .q     (idx)
  );

  // Outputs come straight from flops so downstream never sees lookup glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y1 <= 1'b0;
      Y2 <= 1'b0;
    end else begin
      Y1 <= Y1_TT[idx];
      Y2 <= Y2_TT[idx];
    end
  end

endmodule

// File: tb/tb_comb_logic_core.sv
// Scoreboard bench: default instance plus a SYNC_STAGES=2 variant, checked against a reference model.
module tb_comb_logic_core;

  logic clk = 1'b0;
  logic rst_n;
  logic A, B, C, D;
  logic y1_d, y2_d, y1_v, y2_v;
  bit   clk_run = 1'b0;
  bit   rec_en  = 1'b1;

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  comb_logic_core dut_dflt (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .Y1    (y1_d),
    .Y2    (y2_d)
  );

  comb_logic_core #(
    .Y1_TT       (16'h0001),
    .Y2_TT       (16'hFFFE),
    .SYNC_STAGES (2)
  ) dut_var (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .Y1    (y1_v),
    .Y2    (y2_v)
  );

  typedef struct {
    bit         rh;
    int         gen;
    logic [3:0] idx;
  } edge_t;

  typedef struct {
    logic [1:0] d;
    logic [1:0] v;
    int         e;
  } exp_t;

  edge_t hist[$];
  exp_t  exp_q[$];
  int    gen    = 0;
  int    checks = 0;
  int    errors = 0;

  // Boolean functions written directly, independent of the truth-table constants.
  function automatic logic [1:0] ref_fn(bit variant, logic [3:0] x);
    if (variant) return {x == 4'd0, x != 4'd0};
    return {(x[3] & ~x[2]) | (x[1] & x[0]), ^x};
  endfunction

  // Output after edge e: the lookup sees the input present lat edges earlier,
  // or zero if a reset has occurred since then.
  function automatic logic [1:0] expect_at(int e, int lat, bit variant);
    int src;
    logic [3:0] x;
    if (!hist[e].rh) return 2'b00;
    src = e - lat;
    x = 4'd0;
    if (src >= 0 && hist[src].rh && hist[src].gen == hist[e].gen) x = hist[src].idx;
    return ref_fn(variant, x);
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got Y1Y2=%b expected %b", name, act, exp);
    end
  endtask

  always @(negedge rst_n) gen++;

  always @(posedge clk) begin : recorder
    edge_t h;
    int    e;
    if (rec_en) begin
      h.rh  = rst_n;
      h.gen = gen;
      h.idx = {A, B, C, D};
      hist.push_back(h);
      e = hist.size() - 1;
      exp_q.push_back('{expect_at(e, 0, 1'b0), expect_at(e, 2, 1'b1), e});
    end
  end

  always @(negedge clk) begin : monitor
    exp_t it;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      chk($sformatf("edge%0d_dflt", it.e), {y1_d, y2_d}, it.d);
      chk($sformatf("edge%0d_var", it.e), {y1_v, y2_v}, it.v);
    end
  end

  task automatic drive(input logic [3:0] x);
    {A, B, C, D} = x;
  endtask

  task automatic cyc(input logic [3:0] x);
    @(posedge clk);
    #2 drive(x);
  endtask

  // Toggle inputs between edges and confirm outputs hold the last registered value.
  task automatic cyc_glitch(input logic [3:0] x);
    int e;
    @(posedge clk);
    #2 drive(x);
    #5 drive(~x);
    #1;
    e = hist.size() - 1;
    chk("glitch_hold_dflt", {y1_d, y2_d}, expect_at(e, 0, 1'b0));
    chk("glitch_hold_var", {y1_v, y2_v}, expect_at(e, 2, 1'b1));
    #1 drive(x);
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #6 rst_n = 1'b0;
    #1;
    chk("midrst_dflt", {y1_d, y2_d}, 2'b00);
    chk("midrst_var", {y1_v, y2_v}, 2'b00);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(4'b1011);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_noclk_dflt", {y1_d, y2_d}, 2'b00);
    chk("rst_noclk_var", {y1_v, y2_v}, 2'b00);
    #20;
    chk("rst_hold_dflt", {y1_d, y2_d}, 2'b00);
    chk("rst_hold_var", {y1_v, y2_v}, 2'b00);

    clk_run = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(4'b0101);

    cyc(4'b1001);
    cyc(4'b1011);
    cyc(4'b0101);

    for (int i = 0; i < 16; i++) cyc_glitch(4'(i));

    repeat (3) cyc(4'b1011);
    rst_pulse();
    repeat (4) cyc(4'b1011);

    repeat (4) cyc(4'd15);
    repeat (4) cyc(4'd0);
    repeat (4) cyc(4'd5);

    repeat (300) begin
      if ($urandom_range(0, 19) == 0) rst_pulse();
      else if ($urandom_range(0, 3) == 0) cyc_glitch(4'($urandom_range(0, 15)));
      else cyc(4'($urandom_range(0, 15)));
    end

    @(posedge clk);
    #2 rec_en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
